// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between an I-cache refill port,
// a D-cache refill port and a write buffer.
// Refills are 8-word line bursts (one word per cycle, combinational RAM read);
// write-buffer entries are written one per WRITE cycle.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   i_req/i_addr              I-cache refill request (held until i_done)
//   i_valid/i_done            I-cache refill word strobe / last-word pulse
//   d_req/d_addr              D-cache refill request (held until d_done)
//   d_valid/d_done            D-cache refill word strobe / last-word pulse
//   fill_data/fill_word       shared refill word and its index in the line
//   wb_req/wb_addr/wb_data    write buffer head entry
//   wb_ack                    head entry written this cycle
//   ram_addr/ram_rdata        RAM address / combinational read data
//   ram_we/ram_wdata          RAM write enable / write data
//   busy                      arbiter is not idle
module ram_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_valid,
  output logic        i_done,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  output logic        d_valid,
  output logic        d_done,
  output logic [31:0] fill_data,
  output logic [2:0]  fill_word,
  input  logic        wb_req,
  input  logic [31:0] wb_addr,
  input  logic [31:0] wb_data,
  output logic        wb_ack,
  output logic [31:0] ram_addr,
  input  logic [31:0] ram_rdata,
  output logic        ram_we,
  output logic [31:0] ram_wdata,
  output logic        busy
);

  localparam int unsigned TAG_W = 27;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL_I = 2'd1,
    FILL_D = 2'd2,
    WRITE  = 2'd3
  } state_t;

  state_t             state;
  state_t             grant;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic [1:0]         starve;
  logic               last_fill;   // 1: last fill went to I, so D wins a tie
  logic [TAG_W-1:0]   tag;
  logic [TAG_W-1:0]   grant_tag;
  logic               raw_hit;
  logic               unused_bits;

  // Word offsets are always generated internally from the burst counter.
  assign unused_bits = ^{i_addr[4:0], d_addr[4:0]};

  // A pending write to the line the D-cache is about to refill must land first.
  assign raw_hit  = d_req && wb_req && (wb_addr[31:5] == d_addr[31:5]);
  assign cnt_next = cnt + CNT_W'(1);

  // Grant decision, only acted on in IDLE.
  always_comb begin
    grant = IDLE;
    if (raw_hit) begin
      grant = WRITE;
    end else if (wb_req && (starve == 2'd3)) begin
      grant = WRITE;
    end else if (i_req && d_req) begin
      grant = last_fill ? FILL_D : FILL_I;
    end else if (i_req) begin
      grant = FILL_I;
    end else if (d_req) begin
      grant = FILL_D;
    end else if (wb_req) begin
      grant = WRITE;
    end
  end

  assign grant_tag = (grant == FILL_I) ? i_addr[31:5] : d_addr[31:5];

  // RAM read is combinational, so refill data passes straight through while valid.
  assign fill_data = (i_valid || d_valid) ? ram_rdata : 32'd0;

  // State machine with registered outputs for the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      starve    <= 2'd0;
      last_fill <= 1'b0;
      tag       <= '0;
      i_valid   <= 1'b0;
      i_done    <= 1'b0;
      d_valid   <= 1'b0;
      d_done    <= 1'b0;
      fill_word <= '0;
      wb_ack    <= 1'b0;
      ram_addr  <= 32'd0;
      ram_we    <= 1'b0;
      ram_wdata <= 32'd0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= grant;
          case (grant)
            FILL_I, FILL_D: begin
              tag       <= grant_tag;
              cnt       <= '0;
              last_fill <= (grant == FILL_I);
              // Count fills that overtook a waiting write buffer.
              if (!wb_req)               starve <= 2'd0;
              else if (starve != 2'd3)   starve <= starve + 2'd1;
              ram_addr  <= {grant_tag, 5'd0};
              fill_word <= '0;
              i_valid   <= (grant == FILL_I);
              d_valid   <= (grant == FILL_D);
              busy      <= 1'b1;
            end
            WRITE: begin
              starve    <= 2'd0;
              ram_addr  <= wb_addr;
              ram_wdata <= wb_data;
              ram_we    <= 1'b1;
              wb_ack    <= 1'b1;
              busy      <= 1'b1;
            end
            IDLE: begin
              if (!wb_req) starve <= 2'd0;
            end
          endcase
        end

        FILL_I, FILL_D: begin
          if (cnt == 3'd7) begin
            state     <= IDLE;
            cnt       <= '0;
            i_valid   <= 1'b0;
            d_valid   <= 1'b0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
            fill_word <= '0;
            ram_addr  <= 32'd0;
            busy      <= 1'b0;
          end else begin
            cnt       <= cnt_next;
            fill_word <= cnt_next;
            ram_addr  <= {tag, cnt_next, 2'b00};
            // Done rides along with the last word of the burst.
            i_done    <= (state == FILL_I) && (cnt_next == 3'd7);
            d_done    <= (state == FILL_D) && (cnt_next == 3'd7);
          end
        end

        WRITE: begin
          state     <= IDLE;
          ram_we    <= 1'b0;
          wb_ack    <= 1'b0;
          ram_addr  <= 32'd0;
          ram_wdata <= 32'd0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a RAM model, a write-buffer model and an
// in-order scoreboard of expected refill beats and write events.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req;
  logic [31:0] i_addr, d_addr;
  logic        i_valid, i_done, d_valid, d_done;
  logic [31:0] fill_data;
  logic [2:0]  fill_word;
  logic        wb_req;
  logic [31:0] wb_addr, wb_data;
  logic        wb_ack;
  logic [31:0] ram_addr, ram_rdata, ram_wdata;
  logic        ram_we, busy;

  ram_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_done(i_done),
    .d_req(d_req), .d_addr(d_addr), .d_valid(d_valid), .d_done(d_done),
    .fill_data(fill_data), .fill_word(fill_word),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ack(wb_ack),
    .ram_addr(ram_addr), .ram_rdata(ram_rdata), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  kind;   // 0 I beat, 1 D beat, 2 write
    logic [2:0]  word;
    logic [31:0] data;
    logic        done;   // done pulse for beats, ram_we for writes
    logic [31:0] addr;
  } ev_t;

  ev_t  sb[$];
  int   done_cyc[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   c0;
  int   t;
  logic [31:0] gold [0:1023];
  logic [31:0] mem  [0:1023];
  logic        mem_ready = 1'b0;
  logic [31:0] wb_a [0:7];
  logic [31:0] wb_d [0:7];
  int   wb_head = 0;
  int   wb_tail = 0;
  ev_t  mon_o, mon_e;

  function automatic logic [31:0] pat(input int i);
    if (i >= 32'h50 && i < 32'h58) return 32'(i - 32'h50);
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RAM model: combinational read, write on rising edge.
  assign ram_rdata = mem[ram_addr[11:2]];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!mem_ready) begin
      for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
      mem_ready <= 1'b1;
    end else if (ram_we) begin
      mem[ram_addr[11:2]] <= ram_wdata;
    end
  end

  // Write buffer model.
  assign wb_req  = (wb_head != wb_tail);
  assign wb_addr = wb_a[wb_head[2:0]];
  assign wb_data = wb_d[wb_head[2:0]];

  // Monitor: per-cycle exclusivity plus in-order scoreboard compare.
  always @(negedge clk) begin
    if (!rst) begin
      check("exclusive", 128'({i_valid & d_valid, (i_valid | d_valid) & ram_we,
                               i_done & ~i_valid, d_done & ~d_valid, wb_ack ^ ram_we}), 128'(0));
      if (i_valid || d_valid || wb_ack) begin
        mon_o.kind = d_valid ? 2'd1 : (i_valid ? 2'd0 : 2'd2);
        mon_o.word = wb_ack ? 3'd0 : fill_word;
        mon_o.data = wb_ack ? ram_wdata : fill_data;
        mon_o.done = wb_ack ? ram_we : (d_valid ? d_done : i_done);
        mon_o.addr = ram_addr;
        if (sb.size() == 0) begin
          tests++;
          assert (sb.size() != 0) else begin
            fails++;
            $error("FAIL sb_underflow: got event %0h expected none", mon_o);
          end
        end else begin
          mon_e = sb.pop_front();
          check("event", 128'(mon_o), 128'(mon_e));
        end
        if (mon_o.done && mon_o.kind != 2'd2) done_cyc.push_back(cyc);
        if (wb_ack) wb_head++;
      end
    end
  end

  task automatic push_fill(input logic [1:0] kind, input logic [31:0] line);
    ev_t e;
    for (int w = 0; w < 8; w++) begin
      e.kind = kind;
      e.word = 3'(w);
      e.data = gold[line[11:2] + 10'(w)];
      e.done = (w == 7);
      e.addr = line | 32'(w << 2);
      sb.push_back(e);
    end
  endtask

  task automatic wb_put(input logic [31:0] a, input logic [31:0] d);
    wb_a[wb_tail[2:0]] = a;
    wb_d[wb_tail[2:0]] = d;
    wb_tail++;
  endtask

  task automatic exp_write(input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = 2'd2; e.word = 3'd0; e.data = d; e.done = 1'b1; e.addr = a;
    sb.push_back(e);
    gold[a[11:2]] = d;
  endtask

  task automatic wait_dones(input int n, input int budget, input string tag);
    int seen = 0;
    int k = 0;
    while (seen < n && k < budget) begin
      @(negedge clk);
      k++;
      if (i_done || d_done) seen++;
    end
    check(tag, 128'(seen), 128'(n));
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while ((sb.size() != 0 || busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 128'(sb.size()), 128'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_req = 1'b0;
    d_req = 1'b0;
    sb.delete();
    done_cyc.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; i_addr = 32'd0; d_addr = 32'd0;
    for (int i = 0; i < 1024; i++) gold[i] = pat(i);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_fills", 128'({i_valid, i_done, d_valid, d_done, fill_data, fill_word}), 128'(0));
    check("rst_ram", 128'({ram_addr, ram_we, ram_wdata, wb_ack}), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));

    // D refill of line 0x140, words 0..7, first word one cycle after the request.
    d_addr = 32'h0000_0140;
    push_fill(2'd1, 32'h140);
    c0 = cyc;
    d_req = 1'b1;
    wait_dones(1, 40, "dfill_done");
    d_req = 1'b0;
    wait_idle(20, "dfill_drain");
    check("dfill_ndone", 128'(done_cyc.size()), 128'(1));
    if (done_cyc.size() >= 1) check("dfill_latency", 128'(done_cyc[0]), 128'(c0 + 8));

    // Round-robin: both held after reset -> I, D, I, D with one idle cycle between.
    do_reset();
    i_addr = 32'h0000_0080;
    d_addr = 32'h0000_01C0;
    push_fill(2'd0, 32'h080); push_fill(2'd1, 32'h1C0);
    push_fill(2'd0, 32'h080); push_fill(2'd1, 32'h1C0);
    c0 = cyc;
    i_req = 1'b1; d_req = 1'b1;
    wait_dones(4, 120, "rr_dones");
    i_req = 1'b0; d_req = 1'b0;
    wait_idle(20, "rr_drain");
    check("rr_ndone", 128'(done_cyc.size()), 128'(4));
    if (done_cyc.size() == 4) begin
      check("rr_first", 128'(done_cyc[0]), 128'(c0 + 8));
      for (int k = 1; k < 4; k++) check("rr_gap", 128'(done_cyc[k] - done_cyc[k-1]), 128'(9));
    end

    // Read-after-write: both buffered writes to the D line go first.
    do_reset();
    wb_put(32'h0000_0040, 32'hDEAD_0040);
    wb_put(32'h0000_0044, 32'hBEEF_0044);
    exp_write(32'h0000_0040, 32'hDEAD_0040);
    exp_write(32'h0000_0044, 32'hBEEF_0044);
    push_fill(2'd1, 32'h040);
    d_addr = 32'h0000_0044;
    d_req = 1'b1;
    wait_dones(1, 60, "raw_done");
    d_req = 1'b0;
    wait_idle(20, "raw_drain");
    check("raw_wb_empty", 128'(wb_tail - wb_head), 128'(0));

    // Starvation: three fills overtake the buffer, then WRITE; counter restarts.
    do_reset();
    wb_put(32'h0000_0300, 32'h1234_0300);
    wb_put(32'h0000_0304, 32'h1234_0304);
    push_fill(2'd0, 32'h200); push_fill(2'd1, 32'h280); push_fill(2'd0, 32'h200);
    exp_write(32'h0000_0300, 32'h1234_0300);
    push_fill(2'd1, 32'h280); push_fill(2'd0, 32'h200); push_fill(2'd1, 32'h280);
    exp_write(32'h0000_0304, 32'h1234_0304);
    i_addr = 32'h0000_0200;
    d_addr = 32'h0000_0280;
    i_req = 1'b1; d_req = 1'b1;
    wait_dones(6, 200, "starve_dones");
    i_req = 1'b0; d_req = 1'b0;
    wait_idle(20, "starve_drain");
    check("starve_wb_empty", 128'(wb_tail - wb_head), 128'(0));

    // Reset at word 4 of an I refill abandons it; a held D request then wins.
    do_reset();
    i_addr = 32'h0000_0100;
    push_fill(2'd0, 32'h100);
    i_req = 1'b1;
    t = 0;
    while (!(i_valid && fill_word == 3'd4) && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("midrst_word4", 128'({i_valid, fill_word}), 128'({1'b1, 3'd4}));
    #1 rst = 1'b1;
    #1;
    check("midrst_outs", 128'({i_valid, i_done, d_valid, d_done, fill_data, fill_word, busy}), 128'(0));
    check("midrst_ram", 128'({ram_addr, ram_we, ram_wdata, wb_ack}), 128'(0));
    sb.delete();
    done_cyc.delete();
    i_req = 1'b0;
    d_addr = 32'h0000_0180;
    d_req = 1'b1;
    push_fill(2'd1, 32'h180);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_dones(1, 40, "midrst_d_done");
    d_req = 1'b0;
    wait_idle(20, "midrst_drain");
    check("midrst_ndone", 128'(done_cyc.size()), 128'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
